// File: rtl/cpu_defs.sv
// Phase codes and opcodes shared by the state controller and the control decoder.
// Pure definitions: no latency, no flow control.
package cpu_defs;

   typedef enum logic [2:0] {
      S_IF      = 3'b000,
      S_ID      = 3'b001,
      S_EXE_MEM = 3'b010,
      S_MEM     = 3'b011,
      S_WB_LD   = 3'b100,
      S_EXE_BR  = 3'b101,
      S_EXE_R   = 3'b110,
      S_WB_R    = 3'b111
   } state_e;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_MOVE = 6'b100000;
   localparam logic [5:0] OP_SLT  = 6'b100111;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JR   = 6'b111001;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [2:0] {
      OC_ALU,
      OC_BEQ,
      OC_MEM,
      OC_JUMP,
      OC_HALT,
      OC_ILLEGAL
   } op_class_e;

   function automatic op_class_e op_class(input logic [5:0] op);
      op_class_e oc;
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
         OP_ORI, OP_SLL, OP_MOVE, OP_SLT:  oc = OC_ALU;
         OP_BEQ:                           oc = OC_BEQ;
         OP_SW, OP_LW:                     oc = OC_MEM;
         OP_J, OP_JR, OP_JAL:              oc = OC_JUMP;
         OP_HALT:                          oc = OC_HALT;
         default:                          oc = OC_ILLEGAL;
      endcase
      return oc;
   endfunction

endpackage

// File: rtl/cpu_state_ctrl_if.sv
// Opcode/memory-ready inputs and phase/status outputs of the state controller.
// master = controller side, slave = decoder/memory side.
interface cpu_state_ctrl_if;
   logic [5:0]  decode;
   logic        mem_ready;
   logic [2:0]  state;
   logic        halted;
   logic        instr_done;
   logic        illegal;
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;

   modport master (
      input  decode, mem_ready,
      output state, halted, instr_done, illegal, cycle_cnt, instr_cnt
   );

   modport slave (
      output decode, mem_ready,
      input  state, halted, instr_done, illegal, cycle_cnt, instr_cnt
   );
endinterface

// File: rtl/perf_counter.sv
// Free-running cycle and retired-instruction counters, wrapping at 2^32; present only with PERF_CNT_EN.
// One-cycle update latency; no backpressure.
`ifdef PERF_CNT_EN
module perf_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cyc_inc,
   input  logic        ins_inc,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (cyc_inc) cycle_cnt <= cycle_cnt + 32'd1;
         if (ins_inc) instr_cnt <= instr_cnt + 32'd1;
      end
   end

endmodule
`endif

// File: rtl/cpu_state_ctrl.sv
// Multi-cycle CPU phase sequencer: registered phase, instr_done/illegal combinational from phase+opcode.
// Only MEM stalls (on mem_ready); PERF_CNT_EN adds cycle/instruction counters.
module cpu_state_ctrl
   import cpu_defs::*;
(
   input  logic              CLK,
   input  logic              Reset,
   cpu_state_ctrl_if.master  bus
);

   state_e    st, st_nxt;
   op_class_e oc;
   logic      halted_q;
   logic      set_halt;
   logic      done;
   logic      ill;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         st       <= S_IF;
         halted_q <= 1'b0;
      end else begin
         st <= st_nxt;
         if (set_halt) halted_q <= 1'b1;
      end
   end

   always_comb begin
      st_nxt   = st;
      set_halt = 1'b0;
      done     = 1'b0;
      ill      = 1'b0;
      oc       = op_class(bus.decode);
      case (st)
         S_IF:      st_nxt = halted_q ? S_IF : S_ID;
         S_ID: begin
            case (oc)
               OC_ALU:  st_nxt = S_EXE_R;
               OC_BEQ:  st_nxt = S_EXE_BR;
               OC_MEM:  st_nxt = S_EXE_MEM;
               OC_JUMP: begin
                  st_nxt = S_IF;
                  done   = 1'b1;
               end
               OC_HALT: begin
                  st_nxt   = S_IF;
                  done     = 1'b1;
                  set_halt = 1'b1;
               end
               default: begin
                  st_nxt = S_IF;
                  done   = 1'b1;
                  ill    = 1'b1;
               end
            endcase
         end
         S_EXE_R:   st_nxt = S_WB_R;
         S_WB_R: begin
            st_nxt = S_IF;
            done   = 1'b1;
         end
         S_EXE_BR: begin
            st_nxt = S_IF;
            done   = 1'b1;
         end
         S_EXE_MEM: st_nxt = S_MEM;
         S_MEM: begin
            // Only Lw/Sw reach MEM; anything that is not Lw retires here like a store.
            if (bus.mem_ready) begin
               if (bus.decode == OP_LW) begin
                  st_nxt = S_WB_LD;
               end else begin
                  st_nxt = S_IF;
                  done   = 1'b1;
               end
            end
         end
         S_WB_LD: begin
            st_nxt = S_IF;
            done   = 1'b1;
         end
         default:   st_nxt = S_IF;
      endcase
   end

   assign bus.state      = st;
   assign bus.halted     = halted_q;
   assign bus.instr_done = done & ~halted_q;
   assign bus.illegal    = ill & ~halted_q;

`ifdef PERF_CNT_EN
   perf_counter u_perf_counter (
      .clk       (CLK),
      .rst_n     (Reset),
      .cyc_inc   (~halted_q),
      .ins_inc   (bus.instr_done),
      .cycle_cnt (bus.cycle_cnt),
      .instr_cnt (bus.instr_cnt)
   );
`else
   assign bus.cycle_cnt = '0;
   assign bus.instr_cnt = '0;
`endif

endmodule

// File: doc/cpu_state_ctrl.md
CPU_STATE_CTRL -- requirements
Module: cpu_state_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port decode, input, 6 bits: opcode of the instruction held in IR.
REQ-004 SHALL have port mem_ready, input, 1 bit: data memory done; sampled only in MEM.
REQ-005 SHALL have port state, output, 3 bits: current phase code, driving the control decoder.
REQ-006 SHALL have port halted, output, 1 bit: sticky, set after Halt is decoded.
REQ-007 SHALL have port instr_done, output, 1 bit: one-cycle pulse on the last cycle of each instruction.
REQ-008 SHALL have port illegal, output, 1 bit: one-cycle pulse when an unknown opcode is seen in ID.
REQ-009 SHALL have port cycle_cnt, output, 32 bits: performance counter (see Configuration).
REQ-010 SHALL have port instr_cnt, output, 32 bits: performance counter (see Configuration).

Function
REQ-011 SHALL use these state codes: IF=000, ID=001, EXE_R=110, WB_R=111, EXE_BR=101, EXE_MEM=010, MEM=011, WB_LD=100.
REQ-012 SHALL use these opcodes: Add 000000, Sub 000001, Addi 000010, Or 010000, And 010001, Ori 010010, Sll 011000, Move 100000, Slt 100111, Sw 110000, Lw 110001, Beq 110100, J 111000, Jr 111001, Jal 111010, Halt 111111.
REQ-013 SHALL always go from IF to ID in one cycle unless halted.
REQ-014 SHALL leave ID as follows: ALU ops (Add, Sub, Addi, Or, And, Ori, Sll, Move, Slt) go to EXE_R; Beq goes to EXE_BR; Sw and Lw go to EXE_MEM; J, Jr and Jal go to IF; Halt goes to IF and sets halted; any other opcode goes to IF.
REQ-015 SHALL sequence EXE_R -> WB_R -> IF, EXE_BR -> IF, and EXE_MEM -> MEM.
REQ-016 SHALL hold in MEM while mem_ready=0; with mem_ready=1, Lw goes to WB_LD and Sw goes to IF.
REQ-017 SHALL go from WB_LD to IF.
REQ-018 SHALL assert instr_done for exactly one cycle in each of: ID for J/Jr/Jal/Halt/illegal; EXE_BR; WB_R; WB_LD; and MEM for Sw when mem_ready=1.
REQ-019 SHALL assert illegal in ID for opcodes outside REQ-012; no state other than IF follows.
REQ-020 SHALL, once halted=1, hold state=IF indefinitely, block further instr_done pulses, and clear halted only on reset.
REQ-021 SHALL give an instruction latency of: J/Jr/Jal 2 cycles, Beq 3, ALU 4, Sw 4+wait, Lw 5+wait.
REQ-022 SHALL ignore decode in every state except ID and MEM.

Reset
REQ-023 SHALL, while Reset=0, force state=IF, halted=0, instr_done=0, illegal=0, cycle_cnt=0, instr_cnt=0 asynchronously.
REQ-024 SHALL start the first IF on the first rising CLK edge after Reset deasserts; a reset mid-instruction, including during a MEM wait, discards that instruction.

Configuration
REQ-025 SHALL, with PERF_CNT_EN defined, increment cycle_cnt every non-halted cycle and increment instr_cnt on each instr_done; both wrap 0xFFFFFFFF -> 0.
REQ-026 SHALL, without PERF_CNT_EN, tie cycle_cnt and instr_cnt to 0 and infer no counter flops.

Structure
REQ-027 SHALL place the state codes and opcode constants in a shared package, cpu_defs, used by this block and the control decoder.
REQ-028 SHALL implement the counters as one sub-module, perf_counter, instantiated only under PERF_CNT_EN; the FSM stays in cpu_state_ctrl.

Verification
REQ-029 Add after reset -> state 000,001,110,111,000; instr_done high only in 111; instr_cnt=1.
REQ-030 Lw with mem_ready low for 3 cycles -> 000,001,010,011,011,011,011,100,000; one instr_done, in state 100.
REQ-031 Beq, then J -> 000,001,101 then 000,001; instr_done pulses in 101 and in 001.
REQ-032 Halt -> 000,001,000 then state held at 000; halted=1; cycle_cnt frozen; new decode values ignored.
REQ-033 decode=101010 in ID -> illegal pulses once; next state 000; instr_cnt increments.
REQ-034 Reset=0 asserted in MEM, asynchronous to CLK -> state=000 and counters=0 immediately; normal sequencing after release.
